// File: rtl/mux_4x1_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4x1 mux.
// One requester holds the mux until it releases or until its hold budget
// runs out while others are waiting. All outputs are registered.
module mux_4x1_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       gclk,
    input  logic       grst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] last, last_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] sel_nxt;
    logic       valid_nxt;

    logic [1:0] win;
    logic [1:0] idx;
    logic       others;
    logic       hold_hit;
    logic       do_grant, do_idle, do_renew, do_inc;

    // Round-robin winner: first requester after `last`; scanning from the far
    // end down lets the nearest hit overwrite. Offset 4 wraps back to `last`.
    always_comb begin
        win = 2'd0;
        idx = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) win = idx;
        end
    end

    // Contention and hold-expiry status for the current owner.
    always_comb begin
        others   = |(req & ~(4'b0001 << owner));
        hold_hit = (hold_cnt == 8'(HOLD_MAX));
    end

    // State register.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and action selection; release outranks hold expiry.
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_idle   = 1'b0;
        do_renew  = 1'b0;
        do_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    do_grant  = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    if (others) begin
                        do_grant = 1'b1;
                    end else begin
                        do_idle   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (hold_hit) begin
                    if (others) do_grant = 1'b1;
                    else        do_renew = 1'b1;
                end else begin
                    do_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping; selects are
    // left alone on idle so the mux keeps routing the last owner.
    always_comb begin
        gnt_nxt   = gnt;
        sel_nxt   = {s1, s0};
        valid_nxt = valid;
        owner_nxt = owner;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        if (do_grant) begin
            gnt_nxt   = 4'b0001 << win;
            sel_nxt   = win;
            valid_nxt = 1'b1;
            owner_nxt = win;
            last_nxt  = win;
            hold_nxt  = 8'd1;
        end
        if (do_idle) begin
            gnt_nxt   = 4'b0000;
            valid_nxt = 1'b0;
        end
        if (do_renew) hold_nxt = 8'd1;
        if (do_inc)   hold_nxt = hold_cnt + 8'd1;
    end

    // Output and pointer registers; pointer resets to 3 so requester 0 leads.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            gnt      <= 4'b0000;
            s1       <= 1'b0;
            s0       <= 1'b0;
            valid    <= 1'b0;
            owner    <= 2'd0;
            last     <= 2'd3;
            hold_cnt <= 8'd0;
        end else begin
            gnt      <= gnt_nxt;
            {s1, s0} <= sel_nxt;
            valid    <= valid_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule
